// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions.
//   - BC baud-select encodings and the baud rate each one selects
//   - divisor helper plus 50 MHz divisor constants shared with the transmitter
//   - receiver FSM state enum and mid-bit sample points
package uart_pkg;

    localparam logic [2:0] BC_9600   = 3'b000;  // also any unlisted code
    localparam logic [2:0] BC_19200  = 3'b001;
    localparam logic [2:0] BC_38400  = 3'b010;
    localparam logic [2:0] BC_57600  = 3'b011;
    localparam logic [2:0] BC_115200 = 3'b100;

    localparam int unsigned BAUD_9600   = 9600;
    localparam int unsigned BAUD_19200  = 19200;
    localparam int unsigned BAUD_38400  = 38400;
    localparam int unsigned BAUD_57600  = 57600;
    localparam int unsigned BAUD_115200 = 115200;

    // Clock cycles per oversample tick, rounded to nearest.
    function automatic int unsigned baud_div(int unsigned clk_hz, int unsigned osr,
                                             int unsigned baud);
        return (clk_hz + (baud * osr) / 2) / (baud * osr);
    endfunction

    // Divisors for the nominal 50 MHz clock at 16x oversampling.
    localparam int unsigned DIV_9600   = baud_div(50_000_000, 16, BAUD_9600);   // 326
    localparam int unsigned DIV_19200  = baud_div(50_000_000, 16, BAUD_19200);  // 163
    localparam int unsigned DIV_38400  = baud_div(50_000_000, 16, BAUD_38400);  // 81
    localparam int unsigned DIV_57600  = baud_div(50_000_000, 16, BAUD_57600);  // 54
    localparam int unsigned DIV_115200 = baud_div(50_000_000, 16, BAUD_115200); // 27

    // Start bit is checked half a bit after the edge, later bits a full bit apart.
    localparam logic [3:0] MID_START = 4'd7;
    localparam logic [3:0] MID_FULL  = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_tick.sv
// uart_rx_tick: oversample tick generator for the receiver.
//   clk, rst : clock, synchronous active-high reset
//   BC       : baud select (already latched by the caller for the frame)
//   clr      : restart the divider so tick phase follows the start edge
//   tick     : one-cycle pulse every divisor clocks
module uart_rx_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned OSR    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] BC,
    input  logic       clr,
    output logic       tick
);

    localparam logic [15:0] LIM_9600   = 16'(baud_div(CLK_HZ, OSR, BAUD_9600) - 1);
    localparam logic [15:0] LIM_19200  = 16'(baud_div(CLK_HZ, OSR, BAUD_19200) - 1);
    localparam logic [15:0] LIM_38400  = 16'(baud_div(CLK_HZ, OSR, BAUD_38400) - 1);
    localparam logic [15:0] LIM_57600  = 16'(baud_div(CLK_HZ, OSR, BAUD_57600) - 1);
    localparam logic [15:0] LIM_115200 = 16'(baud_div(CLK_HZ, OSR, BAUD_115200) - 1);

    logic [15:0] cnt;
    logic [15:0] lim;

    always_comb begin
        lim = LIM_9600;
        case (BC)
            BC_19200:  lim = LIM_19200;
            BC_38400:  lim = LIM_38400;
            BC_57600:  lim = LIM_57600;
            BC_115200: lim = LIM_115200;
            default:   lim = LIM_9600;
        endcase
    end

    // >= keeps the counter sane if the divisor ever shrinks under it.
    assign tick = (cnt >= lim) && !clr;

    always_ff @(posedge clk) begin
        if (rst || clr)      cnt <= '0;
        else if (cnt >= lim) cnt <= '0;
        else                 cnt <= cnt + 16'd1;
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampled UART receive path.
//   clk, rst : 50 MHz clock, synchronous active-high reset
//   Rxi      : asynchronous serial input, idle high
//   BC       : baud select, PbitEna: even parity bit present (both latched at start)
//   RO       : received byte, held until the next frame completes
//   Rdy      : one-cycle strobe marking RO/PErr/FErr valid
//   PErr     : parity mismatch, FErr: stop bit sampled low
//   Busy     : frame in progress (start detected, not yet back in IDLE)
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned OSR    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rxi,
    input  logic [2:0] BC,
    input  logic       PbitEna,
    output logic [7:0] RO,
    output logic       Rdy,
    output logic       PErr,
    output logic       FErr,
    output logic       Busy
);

    rx_state_e  state, state_n;
    logic       rx_meta, rxs, rxs_d;
    logic [1:0] warm;
    logic       armed;
    logic [3:0] scnt, scnt_n;
    logic [2:0] bidx, bidx_n;
    logic [7:0] data, data_n;
    logic       perr, perr_n;
    logic [2:0] bc_q, bc_n;
    logic       pen_q, pen_n;
    logic [7:0] ro_n;
    logic       perr_o_n, ferr_n, rdy_n;
    logic       clr, tick, samp;

    uart_rx_tick #(.CLK_HZ(CLK_HZ), .OSR(OSR)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .BC   (bc_q),
        .clr  (clr),
        .tick (tick)
    );

    assign samp = tick && (scnt == MID_FULL);
    assign Busy = (state != IDLE);

    // The synchronizer resets high, so a line held low through reset would
    // look like a falling edge once real samples arrive. warm marks when rxs
    // carries genuine line data; armed requires a real high before any start.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
            warm    <= 2'b00;
            armed   <= 1'b0;
        end else begin
            rx_meta <= Rxi;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
            warm    <= {warm[0], 1'b1};
            armed   <= armed | (warm[1] & rxs);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            scnt  <= '0;
            bidx  <= '0;
            data  <= '0;
            perr  <= 1'b0;
            bc_q  <= BC_9600;
            pen_q <= 1'b0;
            RO    <= '0;
            PErr  <= 1'b0;
            FErr  <= 1'b0;
            Rdy   <= 1'b0;
        end else begin
            state <= state_n;
            scnt  <= scnt_n;
            bidx  <= bidx_n;
            data  <= data_n;
            perr  <= perr_n;
            bc_q  <= bc_n;
            pen_q <= pen_n;
            RO    <= ro_n;
            PErr  <= perr_o_n;
            FErr  <= ferr_n;
            Rdy   <= rdy_n;
        end
    end

    always_comb begin
        state_n  = state;
        scnt_n   = tick ? scnt + 4'd1 : scnt;
        bidx_n   = bidx;
        data_n   = data;
        perr_n   = perr;
        bc_n     = bc_q;
        pen_n    = pen_q;
        clr      = 1'b0;
        ro_n     = RO;
        perr_o_n = PErr;
        ferr_n   = FErr;
        rdy_n    = 1'b0;

        case (state)
            IDLE: begin
                if (armed && rxs_d && !rxs) begin
                    state_n = START;
                    scnt_n  = '0;
                    bidx_n  = '0;
                    clr     = 1'b1;
                    bc_n    = BC;
                    pen_n   = PbitEna;
                end
            end
            START: begin
                if (tick && scnt == MID_START) begin
                    scnt_n  = '0;
                    state_n = rxs ? IDLE : DATA;  // high at mid-start: glitch
                end
            end
            DATA: begin
                if (samp) begin
                    data_n[bidx] = rxs;
                    bidx_n       = bidx + 3'd1;
                    if (bidx == 3'd7) state_n = pen_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (samp) begin
                    perr_n  = (^data) ^ rxs;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (samp) begin
                    ro_n     = data;
                    perr_o_n = pen_q & perr;
                    ferr_n   = ~rxs;
                    rdy_n    = 1'b1;
                    // Leaving at mid-stop lets the next start edge arrive half a bit later.
                    state_n  = rxs ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

    localparam int CLK = 8_000_000;

    logic       clk = 1'b0;
    logic       rst;
    logic       Rxi;
    logic [2:0] BC;
    logic       PbitEna;
    logic [7:0] RO;
    logic       Rdy, PErr, FErr, Busy;

    uart_receiver #(.CLK_HZ(CLK), .OSR(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .Rxi     (Rxi),
        .BC      (BC),
        .PbitEna (PbitEna),
        .RO      (RO),
        .Rdy     (Rdy),
        .PErr    (PErr),
        .FErr    (FErr),
        .Busy    (Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        longint     lo;
        longint     hi;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         rdy_cnt = 0;
    longint     cyc = 0;
    logic       rst_q = 1'b1;
    logic       rdy_prev = 1'b0;
    logic [7:0] h_ro = 8'h00;
    logic       h_pe = 1'b0;
    logic       h_fe = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Spec-level baud arithmetic: cycles per oversample tick, rounded.
    function automatic int bdiv(input logic [2:0] bc);
        int baud;
        case (bc)
            3'b001:  baud = 19200;
            3'b010:  baud = 38400;
            3'b011:  baud = 57600;
            3'b100:  baud = 115200;
            default: baud = 9600;
        endcase
        return (CLK + baud * 8) / (baud * 16);
    endfunction

    function automatic int bitc_of(input logic [2:0] bc);
        return bdiv(bc) * 16;
    endfunction

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame; queue what the receiver must report and when.
    task automatic send(input logic [7:0] d, input logic pen, input logic bad_par,
                        input int stop_low, input int bitc);
        exp_t e;
        @(posedge clk);
        #1;
        Rxi  = 1'b0;
        e.d  = d;
        e.pe = pen & bad_par;
        e.fe = (stop_low > 0);
        e.lo = cyc + (pen ? 10 : 9) * bitc;
        e.hi = e.lo + bitc;
        q.push_back(e);
        hold(bitc);
        for (int i = 0; i < 8; i++) begin
            Rxi = d[i];
            hold(bitc);
        end
        if (pen) begin
            Rxi = (^d) ^ bad_par;
            hold(bitc);
        end
        if (stop_low > 0) begin
            Rxi = 1'b0;
            hold(bitc * stop_low);
            chk("break_busy", {31'd0, Busy}, 32'd1);
            Rxi = 1'b1;
            hold(bitc);
        end else begin
            Rxi = 1'b1;
            hold(bitc);
        end
    endtask

    // Per-cycle compare against the held expectation.
    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            if (rst_q) begin
                h_ro = 8'h00;
                h_pe = 1'b0;
                h_fe = 1'b0;
                chk("rst_rdy", {31'd0, Rdy}, 32'd0);
                chk("rst_busy", {31'd0, Busy}, 32'd0);
            end else if (Rdy === 1'b1) begin
                rdy_cnt++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rdy got RO=%0h expected no strobe (cycle %0d)", RO, cyc);
                end else begin
                    e = q.pop_front();
                    h_ro = e.d;
                    h_pe = e.pe;
                    h_fe = e.fe;
                    checks++;
                    if (cyc < e.lo + 2 || cyc > e.hi + 4) begin
                        errors++;
                        $display("FAIL rdy_time got %0d expected %0d..%0d", cyc, e.lo + 2, e.hi + 4);
                    end
                end
            end
            chk("rdy_double", {31'd0, Rdy & rdy_prev}, 32'd0);
            rdy_prev = Rdy;
            chk("ro", {24'd0, RO}, {24'd0, h_ro});
            chk("perr", {31'd0, PErr}, {31'd0, h_pe});
            chk("ferr", {31'd0, FErr}, {31'd0, h_fe});
        end
    end

    initial begin
        int n0, bc2, bitc;
        rst = 1'b1; Rxi = 1'b1; BC = 3'b100; PbitEna = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_ro", {24'd0, RO}, 32'h00);
        rst = 1'b0;
        hold(20);

        // 115200, no parity, 0xA5
        n0 = rdy_cnt;
        send(8'hA5, 1'b0, 1'b0, 0, bitc_of(3'b100));
        chk("a5_ro", {24'd0, RO}, 32'hA5);
        chk("a5_perr", {31'd0, PErr}, 32'd0);
        chk("a5_busy", {31'd0, Busy}, 32'd0);
        chk("a5_rdycnt", rdy_cnt - n0, 32'd1);

        // 9600 with even parity, good then bad
        BC = 3'b000; PbitEna = 1'b1;
        send(8'h3C, 1'b1, 1'b0, 0, bitc_of(3'b000));
        chk("3c_perr0", {31'd0, PErr}, 32'd0);
        send(8'h3C, 1'b1, 1'b1, 0, bitc_of(3'b000));
        chk("3c_ro", {24'd0, RO}, 32'h3C);
        chk("3c_perr1", {31'd0, PErr}, 32'd1);

        // 57600 framing error with long low stop, then a clean frame
        BC = 3'b011; PbitEna = 1'b0;
        n0 = rdy_cnt;
        send(8'h55, 1'b0, 1'b0, 3, bitc_of(3'b011));
        chk("55_ferr", {31'd0, FErr}, 32'd1);
        chk("55_rdycnt", rdy_cnt - n0, 32'd1);
        chk("55_idle", {31'd0, Busy}, 32'd0);
        send(8'h81, 1'b0, 1'b0, 0, bitc_of(3'b011));
        chk("81_ro", {24'd0, RO}, 32'h81);
        chk("81_ferr", {31'd0, FErr}, 32'd0);

        // Glitch at 38400, then three back-to-back frames
        BC = 3'b010;
        n0 = rdy_cnt;
        Rxi = 1'b0;
        hold(4 * bdiv(3'b010));
        Rxi = 1'b1;
        hold(2 * bitc_of(3'b010));
        chk("glitch_busy", {31'd0, Busy}, 32'd0);
        chk("glitch_rdy", rdy_cnt - n0, 32'd0);
        send(8'hFF, 1'b0, 1'b0, 0, bitc_of(3'b010));
        send(8'h00, 1'b0, 1'b0, 0, bitc_of(3'b010));
        send(8'h7E, 1'b0, 1'b0, 0, bitc_of(3'b010));
        chk("b2b_rdycnt", rdy_cnt - n0, 32'd3);
        chk("b2b_ro", {24'd0, RO}, 32'h7E);

        // Reset in the middle of the data bits
        BC = 3'b100;
        bitc = bitc_of(3'b100);
        Rxi = 1'b0;
        hold(bitc);
        Rxi = 1'b1; hold(bitc);
        Rxi = 1'b0; hold(bitc);
        Rxi = 1'b1; hold(bitc);
        rst = 1'b1; Rxi = 1'b1;
        hold(1);
        chk("midrst_ro", {24'd0, RO}, 32'h00);
        chk("midrst_busy", {31'd0, Busy}, 32'd0);
        chk("midrst_rdy", {31'd0, Rdy}, 32'd0);
        rst = 1'b0;
        hold(2 * bitc);
        send(8'h12, 1'b0, 1'b0, 0, bitc);
        chk("12_ro", {24'd0, RO}, 32'h12);

        // 19200 with a 2.5% fast sender; BC/PbitEna change mid-frame
        BC = 3'b001; PbitEna = 1'b0;
        bitc = bitc_of(3'b001) * 1000 / 1025;
        fork
            send(8'hC3, 1'b0, 1'b0, 0, bitc);
            begin
                hold(bitc_of(3'b001));
                BC = 3'b100; PbitEna = 1'b1;
            end
        join
        chk("c3_ro", {24'd0, RO}, 32'hC3);
        chk("c3_perr", {31'd0, PErr}, 32'd0);
        chk("c3_ferr", {31'd0, FErr}, 32'd0);

        // Randomized frames
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            logic       pen, bad;
            int         sl;
            bc2 = $urandom_range(2, 4);
            pen = 1'($urandom_range(0, 1));
            bad = ($urandom_range(0, 3) == 0);
            sl  = ($urandom_range(0, 4) == 0) ? 2 : 0;
            d   = 8'($urandom);
            BC = 3'(bc2); PbitEna = pen;
            send(d, pen, bad, sl, bitc_of(3'(bc2)));
            hold($urandom_range(0, bitc_of(3'(bc2)) / 2));
        end

        hold(100);
        chk("queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
